// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter_if
// Description : Bundle of the writeback-arbiter handshake and bus signals.
//               master - pipeline side (EXU/LSU sources, decode lookups)
//               slave  - arbiter side (drives register-file write port,
//                        lsu_ready, exu_stall and pending flags)
//   EXU   : exu_wen, exu_waddr[4:0], exu_wdata[31:0], exu_stall
//   LSU   : lsu_valid, lsu_ready, lsu_waddr[4:0], lsu_wdata[31:0]
//   RegF  : reg_wen, reg_waddr[4:0], reg_wdata[31:0]
//   Decode: rs1_addr/rs2_addr[4:0], rs1_pend/rs2_pend
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_arbiter_if;
  logic        exu_wen;
  logic [4:0]  exu_waddr;
  logic [31:0] exu_wdata;
  logic        exu_stall;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_waddr;
  logic [31:0] lsu_wdata;
  logic        reg_wen;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rs1_pend;
  logic        rs2_pend;

  modport master (
    output exu_wen, exu_waddr, exu_wdata,
    output lsu_valid, lsu_waddr, lsu_wdata,
    output rs1_addr, rs2_addr,
    input  exu_stall, lsu_ready,
    input  reg_wen, reg_waddr, reg_wdata,
    input  rs1_pend, rs2_pend
  );

  modport slave (
    input  exu_wen, exu_waddr, exu_wdata,
    input  lsu_valid, lsu_waddr, lsu_wdata,
    input  rs1_addr, rs2_addr,
    output exu_stall, lsu_ready,
    output reg_wen, reg_waddr, reg_wdata,
    output rs1_pend, rs2_pend
  );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Shares the single register-file write port between the
//               single-cycle EXU and the long-latency LSU/MDU. LSU results
//               that lose arbitration are held in a DEPTH-entry FIFO and
//               drained on cycles without an EXU write. Decode can query
//               whether a source register is still waiting in the FIFO.
// Ports       : sys_clk, sys_rst (sync, active-high)
//               bus     - regfile_wb_arbiter_if.slave (EXU, LSU, register
//                         file write port, decode pending lookups)
//               q_count - FIFO occupancy, $clog2(DEPTH)+1 bits
// Parameters  : DEPTH      - FIFO entries (power of two, >= 2)
//               STARVE_MAX - head wait limit before an EXU stall is forced
// Options     : WB_STARVE_EN - enables the starvation counter and exu_stall;
//               when undefined exu_stall is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  wire logic                   sys_clk,
  input  wire logic                   sys_rst,
  regfile_wb_arbiter_if.slave         bus,
  output logic [$clog2(DEPTH):0]      q_count
);

  localparam int                 c_PTR_W = $clog2(DEPTH);
  localparam logic [c_PTR_W:0]   c_FULL  = (c_PTR_W+1)'(DEPTH);

  logic [4:0]         r_q_addr [DEPTH];
  logic [31:0]        r_q_data [DEPTH];
  logic [DEPTH-1:0]   r_vld;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;

  logic w_full, w_empty, w_stall, w_exu_act;
  logic w_lsu_xfer, w_lsu_nz, w_pop, w_byp, w_push;
  logic w_p1, w_p2;

  assign w_full  = (r_count == c_FULL);
  assign w_empty = (r_count == '0);

  // Ready depends only on registered occupancy, never on lsu_valid.
  assign bus.lsu_ready = !w_full;
  assign w_lsu_xfer    = bus.lsu_valid && !w_full;
  assign w_lsu_nz      = (bus.lsu_waddr != 5'd0);

  assign w_exu_act = bus.exu_wen && (bus.exu_waddr != 5'd0) && !w_stall;

  // Queue-side writes are blocked during reset so discarded entries are
  // never committed to the register file.
  assign w_pop  = !w_exu_act && !w_empty && !sys_rst;
  assign w_byp  = !w_exu_act && w_empty && w_lsu_xfer && w_lsu_nz && !sys_rst;
  assign w_push = w_lsu_xfer && w_lsu_nz && !w_byp && !sys_rst;

  // Write-port mux: EXU, then FIFO head, then LSU bypass.
  always_comb begin
    bus.reg_wen   = 1'b0;
    bus.reg_waddr = 5'd0;
    bus.reg_wdata = 32'd0;
    if (w_exu_act) begin
      bus.reg_wen   = 1'b1;
      bus.reg_waddr = bus.exu_waddr;
      bus.reg_wdata = bus.exu_wdata;
    end else if (w_pop) begin
      bus.reg_wen   = 1'b1;
      bus.reg_waddr = r_q_addr[r_rd_ptr];
      bus.reg_wdata = r_q_data[r_rd_ptr];
    end else if (w_byp) begin
      bus.reg_wen   = 1'b1;
      bus.reg_waddr = bus.lsu_waddr;
      bus.reg_wdata = bus.lsu_wdata;
    end
  end

  // FIFO state. Push and pop never target the same slot: a pop needs a
  // non-empty queue and a push needs a non-full one.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_vld    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_q_addr[r_wr_ptr] <= bus.lsu_waddr;
        r_q_data[r_wr_ptr] <= bus.lsu_wdata;
        r_vld[r_wr_ptr]    <= 1'b1;
        r_wr_ptr           <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + c_PTR_W'(1);
      end
      if (w_push && !w_pop)
        r_count <= r_count + (c_PTR_W+1)'(1);
      else if (w_pop && !w_push)
        r_count <= r_count - (c_PTR_W+1)'(1);
    end
  end

  assign q_count = r_count;

  // Pending lookups: an entry popped this cycle is still flagged, since its
  // register-file write only lands at the coming edge.
  always_comb begin
    w_p1 = 1'b0;
    w_p2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && (r_q_addr[i] == bus.rs1_addr)) w_p1 = 1'b1;
      if (r_vld[i] && (r_q_addr[i] == bus.rs2_addr)) w_p2 = 1'b1;
    end
  end

  assign bus.rs1_pend = w_p1 && (bus.rs1_addr != 5'd0);
  assign bus.rs2_pend = w_p2 && (bus.rs2_addr != 5'd0);

`ifdef WB_STARVE_EN
  localparam int               c_SW   = $clog2(STARVE_MAX + 1);
  localparam logic [c_SW-1:0]  c_SMAX = c_SW'(STARVE_MAX);

  logic [c_SW-1:0] r_starve;

  // A stall gives the head the port: when the starve limit is hit, or when
  // the queue is full while the EXU wants to write (forces a drain).
  assign w_stall = (r_starve == c_SMAX) || (w_full && bus.exu_wen);

  always_ff @(posedge sys_clk) begin
    if (sys_rst || w_empty || w_pop)
      r_starve <= '0;
    else
      r_starve <= r_starve + c_SW'(1);
  end
`else
  localparam logic [31:0] c_STARVE_MAX = STARVE_MAX;
  logic w_unused_starve;

  assign w_stall         = 1'b0;
  assign w_unused_starve = ^c_STARVE_MAX;
`endif

  assign bus.exu_stall = w_stall;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Self-checking bench for regfile_wb_arbiter. Expected register
//               writes are queued in a scoreboard as stimulus is driven and
//               compared in order whenever reg_wen is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;
  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic [$clog2(DEPTH):0] q_count;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus.slave),
    .q_count (q_count)
  );

  always #5 sys_clk = ~sys_clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [36:0] sb[$];
  logic [36:0] lq[$];
  bit          mon_en  = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every register-file write must match the scoreboard head.
  always @(negedge sys_clk) begin
    if (mon_en && bus.reg_wen) begin
      if (sb.size() == 0)
        check("unexp_wr", 64'(bus.reg_wen), 64'd0);
      else
        check("wr", 64'({bus.reg_waddr, bus.reg_wdata}), 64'(sb.pop_front()));
    end
  end

  task automatic drive(input logic ew, input logic [4:0] ea, input logic [31:0] ed,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    bus.exu_wen   = ew;
    bus.exu_waddr = ea;
    bus.exu_wdata = ed;
    bus.lsu_valid = lv;
    bus.lsu_waddr = la;
    bus.lsu_wdata = ld;
  endtask

  task automatic mid();
    @(negedge sys_clk);
  endtask

  task automatic next();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    bus.rs1_addr = 5'd1;
    bus.rs2_addr = 5'd2;
    sys_rst = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    mon_en  = 1'b1;

    // Reset state
    mid();
    check("rst_ready", 64'(bus.lsu_ready), 64'd1);
    check("rst_stall", 64'(bus.exu_stall), 64'd0);
    check("rst_count", 64'(q_count), 64'd0);
    check("rst_pend1", 64'(bus.rs1_pend), 64'd0);
    check("rst_pend2", 64'(bus.rs2_pend), 64'd0);
    check("rst_wen",   64'(bus.reg_wen), 64'd0);
    next();

    // EXU write, same cycle
    drive(1, 5, 32'h11, 0, 0, 0);
    sb.push_back({5'd5, 32'h11});
    mid();
    check("exu_wen",   64'(bus.reg_wen), 64'd1);
    check("exu_waddr", 64'(bus.reg_waddr), 64'd5);
    check("exu_wdata", 64'(bus.reg_wdata), 64'h11);
    check("exu_ready", 64'(bus.lsu_ready), 64'd1);
    check("exu_count", 64'(q_count), 64'd0);
    next();

    // LSU bypass when EXU idle and queue empty
    drive(0, 0, 0, 1, 7, 32'hAA);
    sb.push_back({5'd7, 32'hAA});
    mid();
    check("byp_waddr", 64'(bus.reg_waddr), 64'd7);
    check("byp_ready", 64'(bus.lsu_ready), 64'd1);
    next();
    check("byp_count", 64'(q_count), 64'd0);

    // Fill the queue while EXU writes every cycle
    for (int i = 1; i <= 4; i++) begin
      drive(1, 5'(9 + i), 32'h1000 + 32'(i), 1, 5'(i), 32'h200 + 32'(i));
      sb.push_back({5'(9 + i), 32'h1000 + 32'(i)});
      lq.push_back({5'(i), 32'h200 + 32'(i)});
      mid();
      next();
    end
    check("full_count", 64'(q_count), 64'd4);
    check("full_ready", 64'(bus.lsu_ready), 64'd0);

    // Drain, with a blocked LSU request and pending lookups
    while (lq.size() > 0) sb.push_back(lq.pop_front());
    drive(0, 0, 0, 1, 20, 32'hDEAD);
    bus.rs1_addr = 5'd3;
    bus.rs2_addr = 5'd0;
    mid();
    check("drA_ready", 64'(bus.lsu_ready), 64'd0);
    check("drA_pend1", 64'(bus.rs1_pend), 64'd1);
    check("drA_pend2", 64'(bus.rs2_pend), 64'd0);
    check("drA_stall", 64'(bus.exu_stall), 64'd0);
    check("drA_count", 64'(q_count), 64'd4);
    next();
    drive(0, 0, 0, 0, 0, 0);
    bus.rs1_addr = 5'd2;
    bus.rs2_addr = 5'd1;
    mid();
    check("drB_pend_pop", 64'(bus.rs1_pend), 64'd1);
    check("drB_pend_gone", 64'(bus.rs2_pend), 64'd0);
    check("drB_count", 64'(q_count), 64'd3);
    next();
    repeat (2) begin
      mid();
      next();
    end
    check("drain_count", 64'(q_count), 64'd0);
    check("drain_sb", 64'(sb.size()), 64'd0);

    // LSU transfer to x0 is accepted and dropped
    drive(0, 0, 0, 1, 0, 32'h55);
    mid();
    check("x0_ready", 64'(bus.lsu_ready), 64'd1);
    check("x0_wen",   64'(bus.reg_wen), 64'd0);
    next();
    check("x0_count", 64'(q_count), 64'd0);
    drive(1, 6, 32'h66, 1, 0, 32'h56);
    sb.push_back({5'd6, 32'h66});
    mid();
    next();
    check("x0b_count", 64'(q_count), 64'd0);

    // Simultaneous push and pop
    drive(1, 8, 32'h88, 1, 21, 32'h2121);
    sb.push_back({5'd8, 32'h88});
    mid();
    next();
    check("pp_count1", 64'(q_count), 64'd1);
    drive(0, 0, 0, 1, 22, 32'h2222);
    sb.push_back({5'd21, 32'h2121});
    mid();
    check("pp_waddr", 64'(bus.reg_waddr), 64'd21);
    next();
    check("pp_count2", 64'(q_count), 64'd1);
    drive(0, 0, 0, 0, 0, 0);
    sb.push_back({5'd22, 32'h2222});
    mid();
    next();
    check("pp_count3", 64'(q_count), 64'd0);

    // Starvation: one queued entry behind continuous EXU writes
    drive(1, 24, 32'h3000, 1, 25, 32'h2525);
    sb.push_back({5'd24, 32'h3000});
    mid();
    next();
    for (int k = 1; k <= 9; k++) begin
      drive(1, 5'(k), 32'h4000 + 32'(k), 0, 0, 0);
`ifdef WB_STARVE_EN
      if (k == 9) begin
        sb.push_back({5'd25, 32'h2525});
        mid();
        check("starve_stall", 64'(bus.exu_stall), 64'd1);
        check("starve_head", 64'(bus.reg_waddr), 64'd25);
      end else begin
        sb.push_back({5'(k), 32'h4000 + 32'(k)});
        mid();
        check("starve_nostall", 64'(bus.exu_stall), 64'd0);
      end
`else
      sb.push_back({5'(k), 32'h4000 + 32'(k)});
      mid();
      check("nostarve_stall", 64'(bus.exu_stall), 64'd0);
`endif
      next();
    end
`ifdef WB_STARVE_EN
    drive(1, 10, 32'h400A, 0, 0, 0);
    sb.push_back({5'd10, 32'h400A});
    mid();
    check("starve_after", 64'(bus.exu_stall), 64'd0);
    check("starve_count", 64'(q_count), 64'd0);
    next();
`else
    check("nostarve_count", 64'(q_count), 64'd1);
    drive(0, 0, 0, 0, 0, 0);
    sb.push_back({5'd25, 32'h2525});
    mid();
    next();
    check("nostarve_drain", 64'(q_count), 64'd0);
`endif

    // Reset discards queued entries
    for (int i = 1; i <= 3; i++) begin
      drive(1, 5'(10 + i), 32'h5000 + 32'(i), 1, 5'(15 + i), 32'h600 + 32'(i));
      sb.push_back({5'(10 + i), 32'h5000 + 32'(i)});
      mid();
      next();
    end
    check("mr_count3", 64'(q_count), 64'd3);
    drive(0, 0, 0, 0, 0, 0);
    sys_rst = 1'b1;
    mid();
    check("mr_wen", 64'(bus.reg_wen), 64'd0);
    next();
    sys_rst = 1'b0;
    bus.rs1_addr = 5'd16;
    bus.rs2_addr = 5'd17;
    mid();
    check("mr_count", 64'(q_count), 64'd0);
    check("mr_pend1", 64'(bus.rs1_pend), 64'd0);
    check("mr_pend2", 64'(bus.rs2_pend), 64'd0);
    check("mr_ready", 64'(bus.lsu_ready), 64'd1);
    next();
    repeat (3) begin
      mid();
      next();
    end
    check("final_sb", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (reg_wen/reg_waddr/reg_wdata) between two writeback sources.
  - EXU: single-cycle, cannot be back-pressured except via a pipeline stall.
  - LSU/MDU: long-latency, valid/ready handshake.
- Losing LSU results are queued in a small FIFO and drained on idle EXU cycles.
- Pending-write lookups let decode interlock on queued destinations.
- Sits between execution/memory stages and register_file.

Parameters:
- DEPTH, 4, LSU result queue entries (power of two, >=2).
- STARVE_MAX, 8, cycles a queue head may wait before forcing an EXU stall (only with WB_STARVE_EN).

Ports:
- sys_clk  in  1  clock
- sys_rst  in  1  synchronous reset, active-high
- exu_wen  in  1  EXU write request this cycle
- exu_waddr  in  5  EXU destination
- exu_wdata  in  32  EXU result
- lsu_valid  in  1  LSU result valid
- lsu_ready  out  1  LSU result accepted
- lsu_waddr  in  5  LSU destination
- lsu_wdata  in  32  LSU result
- exu_stall  out  1  hold EXU/upstream pipeline this cycle
- reg_wen  out  1  to register file write enable
- reg_waddr  out  5  to register file
- reg_wdata  out  32  to register file
- rs1_addr  in  5  decode read address 1
- rs2_addr  in  5  decode read address 2
- rs1_pend  out  1  rs1_addr matches a queued entry
- rs2_pend  out  1  rs2_addr matches a queued entry
- q_count  out  log2(DEPTH)+1  queue occupancy

Behaviour:
- Reset (sys_rst=1 at posedge):
  - queue emptied; count=0; starve counter=0.
  - Outputs after reset: lsu_ready=1, exu_stall=0, rs*_pend=0, q_count=0.
  - reg_wen=0 unless exu_wen is asserted (the write mux is combinational).
- Reset mid-operation discards all queued entries; they are never written.
- Effective EXU request: exu_act = exu_wen && exu_waddr!=0 && !exu_stall.
- Handshake:
  - lsu_ready = !full, registered-state based only; it does not depend on lsu_valid.
  - Transfer when lsu_valid && lsu_ready.
  - LSU transfers with lsu_waddr=0 are accepted and dropped (never enqueued or written).
- Write-port select (combinational, same cycle), priority order:
  1. exu_act: write EXU data.
  2. Else queue non-empty: write head, then pop.
  3. Else LSU transfer with nonzero addr: write LSU data directly (bypass, 0 latency, no enqueue).
  4. Else reg_wen=0.
- Enqueue: LSU transfer with nonzero addr not taken by rule 3 is pushed at the tail.
- Push and pop in the same cycle are legal; count is unchanged. Cannot occur when full, since lsu_ready=0.
- Queue order is strict FIFO. Pointers wrap modulo DEPTH.
- Full: count==DEPTH. Empty: count==0.
- rs1_pend/rs2_pend:
  - Combinational OR over valid queue entries of (waddr==rs_addr).
  - Forced 0 when rs_addr==0.
  - An entry being popped this cycle still counts as pending.
- Without WB_STARVE_EN, exu_stall is constant 0.

Optional Feature:
- Macro WB_STARVE_EN.
- Defined:
  - Starve counter increments each cycle the queue is non-empty and its head is not popped.
  - Counter clears on pop or when empty.
  - When counter==STARVE_MAX, exu_stall=1 for exactly one cycle. exu_act is then 0, so the head is written; counter clears.
  - exu_stall is also asserted for one cycle when the queue is full and exu_wen is high, guaranteeing drain.
- Undefined: counter logic is absent; exu_stall=0; the queue drains only on cycles with no exu_act.

Test Plan:
- Reset, then exu_wen=1 addr=5 data=0x11 → same cycle reg_wen=1, waddr=5, wdata=0x11; lsu_ready=1, q_count=0.
- EXU idle, queue empty, LSU valid addr=7 data=0xAA → direct write waddr=7 same cycle; q_count stays 0.
- EXU writing continuously, LSU pushes addrs 1,2,3,4 → q_count=4, lsu_ready=0; rs1_addr=3 gives rs1_pend=1; rs2_addr=0 gives rs2_pend=0.
  - Then EXU idle 4 cycles → writes 1,2,3,4 in order; q_count=0.
- LSU addr=0 transfer → accepted, no reg_wen, q_count unchanged.
- WB_STARVE_EN, STARVE_MAX=8, EXU writing every cycle, one queued entry → exu_stall=1 on the 9th cycle; head written that cycle; exu_stall=0 next cycle.
- Queue holding 3 entries, sys_rst=1 for one cycle → q_count=0, rs*_pend=0, no queued data ever written.
